// File: rtl/move_btn_conditioner_if.sv
// Player move-button signal bundle: raw button and controls in, conditioned strobe and level out.
interface move_btn_conditioner_if;
   logic btn_raw;
   logic repeat_en;
   logic enable;
   logic move_pulse;
   logic btn_level;

   modport master (
      output btn_raw,
      output repeat_en,
      output enable,
      input  move_pulse,
      input  btn_level
   );

   modport slave (
      input  btn_raw,
      input  repeat_en,
      input  enable,
      output move_pulse,
      output btn_level
   );
endinterface

// File: rtl/move_btn_conditioner.sv
// Move push-button conditioner: 2-flop synchroniser, debounce, press/hold/auto-repeat FSM.
// Emits a registered one-cycle move_pulse per accepted press and per auto-repeat tick.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | button released; waiting for debounced rising level
//   ST_HOLD   | first pulse sent; timing hold delay (saturates if no repeat)
//   ST_REPEAT | auto-repeat active; pulse each time the repeat timer expires
module move_btn_conditioner #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int HOLD_CYCLES     = 12500000,
   parameter int REPEAT_CYCLES   = 5000000,
   parameter int CNT_W           = 24
) (
   input logic                    clk,
   input logic                    rst_n,
   move_btn_conditioner_if.slave  btn
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HOLD   = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   // Timers count down from (N-1) and act on reaching zero.
   localparam logic [CNT_W-1:0] DB_LOAD   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LOAD  = CNT_W'(REPEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic             sync_1;
   logic             sync_q;
   logic [CNT_W-1:0] db_cnt;
   logic             btn_level_q;
   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] tmr;
   logic [CNT_W-1:0] tmr_nxt;
   logic             fire;
   logic             move_pulse_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1 <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         sync_1 <= btn.btn_raw;
         sync_q <= sync_1;
      end
   end

   // Any cycle agreeing with the accepted level restarts the debounce window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_cnt      <= '0;
         btn_level_q <= 1'b0;
      end else if (sync_q == btn_level_q) begin
         db_cnt <= DB_LOAD;
      end else if (db_cnt == '0) begin
         btn_level_q <= sync_q;
         db_cnt      <= DB_LOAD;
      end else begin
         db_cnt <= db_cnt - CNT_ONE;
      end
   end

   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr;
      fire      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (btn_level_q) begin
               fire      = 1'b1;
               tmr_nxt   = HOLD_LOAD;
               state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!btn_level_q) begin
               state_nxt = ST_IDLE;
            end else if (tmr == '0) begin
               // Held at zero while repeat is off, so enabling it later fires at once.
               if (btn.repeat_en) begin
                  fire      = 1'b1;
                  tmr_nxt   = REP_LOAD;
                  state_nxt = ST_REPEAT;
               end
            end else begin
               tmr_nxt = tmr - CNT_ONE;
            end
         end
         ST_REPEAT: begin
            if (!btn_level_q) begin
               state_nxt = ST_IDLE;
            end else if (!btn.repeat_en) begin
               tmr_nxt   = HOLD_LOAD;
               state_nxt = ST_HOLD;
            end else if (tmr == '0) begin
               fire    = 1'b1;
               tmr_nxt = REP_LOAD;
            end else begin
               tmr_nxt = tmr - CNT_ONE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         tmr          <= '0;
         move_pulse_q <= 1'b0;
      end else begin
         state        <= state_nxt;
         tmr          <= tmr_nxt;
         move_pulse_q <= fire & btn.enable;
      end
   end

   assign btn.move_pulse = move_pulse_q;
   assign btn.btn_level  = btn_level_q;

endmodule

// File: tb/tb_move_btn_conditioner.sv
// Directed bench for move_btn_conditioner with short debounce/hold/repeat timing.
module tb_move_btn_conditioner;
   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_bad = 0;

   move_btn_conditioner_if btn_if ();

   move_btn_conditioner #(
      .DEBOUNCE_CYCLES (4),
      .HOLD_CYCLES     (10),
      .REPEAT_CYCLES   (3),
      .CNT_W           (24)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic got, input logic exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Release the button and confirm the level drops after 6 edges with no pulse.
   task automatic release_chk(input string name);
      btn_if.btn_raw = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk($sformatf("%s_rel_level_c%0d", name, k), btn_if.btn_level, k < 6);
         chk($sformatf("%s_rel_pulse_c%0d", name, k), btn_if.move_pulse, 1'b0);
      end
   endtask

   initial begin
      rst_n            = 1'b0;
      btn_if.btn_raw   = 1'b0;
      btn_if.repeat_en = 1'b0;
      btn_if.enable    = 1'b1;
      tick();
      tick();
      chk("reset_level", btn_if.btn_level, 1'b0);
      chk("reset_pulse", btn_if.move_pulse, 1'b0);
      rst_n = 1'b1;
      repeat (3) tick();

      // Clean press, no repeat: level at edge 6, single pulse at edge 7.
      btn_if.btn_raw = 1'b1;
      for (int k = 1; k <= 50; k++) begin
         tick();
         chk($sformatf("clean_level_c%0d", k), btn_if.btn_level, k >= 6);
         chk($sformatf("clean_pulse_c%0d", k), btn_if.move_pulse, k == 7);
      end
      release_chk("clean");

      // Bounce every 2 cycles never survives debounce; final stable edge gives one pulse.
      for (int i = 0; i < 10; i++) begin
         btn_if.btn_raw = (i % 2 == 0);
         repeat (2) begin
            tick();
            chk($sformatf("bounce_level_i%0d", i), btn_if.btn_level, 1'b0);
            chk($sformatf("bounce_pulse_i%0d", i), btn_if.move_pulse, 1'b0);
         end
      end
      btn_if.btn_raw = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         tick();
         chk($sformatf("bounce_fin_level_c%0d", k), btn_if.btn_level, k >= 6);
         chk($sformatf("bounce_fin_pulse_c%0d", k), btn_if.move_pulse, k == 7);
      end
      release_chk("bounce");

      // Auto-repeat: pulses at 7, 17, then every 3; release after edge 47, level falls at 53.
      btn_if.repeat_en = 1'b1;
      btn_if.btn_raw   = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         tick();
         chk($sformatf("rep_level_c%0d", k), btn_if.btn_level, (k >= 6) && (k < 53));
         chk($sformatf("rep_pulse_c%0d", k), btn_if.move_pulse,
             (k == 7) || ((k >= 17) && (k <= 53) && ((k - 17) % 3 == 0)));
         if (k == 47) btn_if.btn_raw = 1'b0;
      end
      repeat (3) tick();

      // Release lands with hold expiry: level falls at 16, edge 17 must not fire.
      btn_if.btn_raw = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         tick();
         chk($sformatf("relexp_level_c%0d", k), btn_if.btn_level, (k >= 6) && (k < 16));
         chk($sformatf("relexp_pulse_c%0d", k), btn_if.move_pulse, k == 7);
         if (k == 10) btn_if.btn_raw = 1'b0;
      end

      // One cycle longer: level still high at expiry, so edge 17 fires.
      btn_if.btn_raw = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         tick();
         chk($sformatf("late_level_c%0d", k), btn_if.btn_level, (k >= 6) && (k < 17));
         chk($sformatf("late_pulse_c%0d", k), btn_if.move_pulse, (k == 7) || (k == 17));
         if (k == 11) btn_if.btn_raw = 1'b0;
      end

      // Enable gating: pulse lost while frozen, not replayed when enable returns.
      btn_if.repeat_en = 1'b0;
      btn_if.enable    = 1'b0;
      btn_if.btn_raw   = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         chk($sformatf("gate_level_c%0d", k), btn_if.btn_level, k >= 6);
         chk($sformatf("gate_pulse_c%0d", k), btn_if.move_pulse, 1'b0);
         if (k == 15) btn_if.enable = 1'b1;
      end
      release_chk("gate");

      // Reset in REPEAT while a pulse is high clears outputs without a clock edge.
      btn_if.repeat_en = 1'b1;
      btn_if.btn_raw   = 1'b1;
      for (int k = 1; k <= 23; k++) begin
         tick();
         chk($sformatf("rst_pre_pulse_c%0d", k), btn_if.move_pulse,
             (k == 7) || ((k >= 17) && ((k - 17) % 3 == 0)));
      end
      rst_n = 1'b0;
      #1;
      chk("rst_async_pulse", btn_if.move_pulse, 1'b0);
      chk("rst_async_level", btn_if.btn_level, 1'b0);
      repeat (3) begin
         tick();
         chk("rst_hold_level", btn_if.btn_level, 1'b0);
         chk("rst_hold_pulse", btn_if.move_pulse, 1'b0);
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk($sformatf("rst_post_level_c%0d", k), btn_if.btn_level, k >= 6);
         chk($sformatf("rst_post_pulse_c%0d", k), btn_if.move_pulse, k == 7);
      end
      btn_if.repeat_en = 1'b0;
      release_chk("rst");

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
